// File: rtl/vga_sync_timing_if.sv
//------------------------------------------------------------------------------
// Module   : vga_sync_timing_if
// Brief    : Raster timing bundle from the sync generator to the pattern stages.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_sync_timing_if;
    logic [9:0]  o_px;
    logic [9:0]  o_py;
    logic        o_active;
    logic        o_frame_start;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_de;
    logic [15:0] o_frame;

    modport master (
        output o_px, o_py, o_active, o_frame_start,
        output o_hsync, o_vsync, o_de, o_frame
    );

    modport slave (
        input o_px, o_py, o_active, o_frame_start,
        input o_hsync, o_vsync, o_de, o_frame
    );
endinterface

`default_nettype wire

// File: rtl/vga_sync_timing.sv
//------------------------------------------------------------------------------
// Module   : vga_sync_timing
// Brief    : Free-running raster counters with sync/DE decode and a delay line.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_sync_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int SYNC_POL = 0,
    parameter int PIPE_DLY = 1
) (
    input  wire logic            i_clk,
    input  wire logic            i_reset,
    vga_sync_timing_if.master    bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_sync_timing: H_TOTAL/V_TOTAL must not exceed 1024");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
            $error("vga_sync_timing: PIPE_DLY must be within 0..4");
        end
    endgenerate

    // 11-bit constants so a full 1024-count range still compares correctly
    localparam logic [9:0]  C_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  C_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] C_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] C_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] C_HS_START = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] C_VS_START = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic        C_SYNC_ON  = 1'(SYNC_POL);
    localparam logic        C_SYNC_OFF = ~C_SYNC_ON;

    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic [15:0] r_frame;
    logic [10:0] w_h_ext;
    logic [10:0] w_v_ext;
    logic        w_active;
    logic        w_hs_lvl;
    logic        w_vs_lvl;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h     <= '0;
            r_v     <= '0;
            r_frame <= '0;
        end else if (r_h == C_H_LAST) begin
            r_h <= '0;
            if (r_v == C_V_LAST) begin
                r_v     <= '0;
                r_frame <= r_frame + 16'd1;
            end else begin
                r_v <= r_v + 10'd1;
            end
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    assign w_h_ext  = {1'b0, r_h};
    assign w_v_ext  = {1'b0, r_v};
    assign w_active = (w_h_ext < C_H_ACT) && (w_v_ext < C_V_ACT);
    assign w_hs_lvl = ((w_h_ext >= C_HS_START) && (w_h_ext < C_HS_END)) ? C_SYNC_ON : C_SYNC_OFF;
    assign w_vs_lvl = ((w_v_ext >= C_VS_START) && (w_v_ext < C_VS_END)) ? C_SYNC_ON : C_SYNC_OFF;

    assign bus.o_px          = r_h;
    assign bus.o_py          = r_v;
    assign bus.o_active      = w_active;
    assign bus.o_frame_start = (r_h == 10'd0) && (r_v == 10'd0);
    assign bus.o_frame       = r_frame;

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign bus.o_hsync = w_hs_lvl;
            assign bus.o_vsync = w_vs_lvl;
            assign bus.o_de    = w_active;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] r_hs_pipe;
            logic [PIPE_DLY-1:0] r_vs_pipe;
            logic [PIPE_DLY-1:0] r_de_pipe;

            // Reset flushes every stage so no stale sync pulse survives an abort
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_hs_pipe <= {PIPE_DLY{C_SYNC_OFF}};
                    r_vs_pipe <= {PIPE_DLY{C_SYNC_OFF}};
                    r_de_pipe <= '0;
                end else begin
                    r_hs_pipe[0] <= w_hs_lvl;
                    r_vs_pipe[0] <= w_vs_lvl;
                    r_de_pipe[0] <= w_active;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        r_hs_pipe[i] <= r_hs_pipe[i-1];
                        r_vs_pipe[i] <= r_vs_pipe[i-1];
                        r_de_pipe[i] <= r_de_pipe[i-1];
                    end
                end
            end

            assign bus.o_hsync = r_hs_pipe[PIPE_DLY-1];
            assign bus.o_vsync = r_vs_pipe[PIPE_DLY-1];
            assign bus.o_de    = r_de_pipe[PIPE_DLY-1];
        end
    endgenerate

endmodule

`default_nettype wire
